imf_sift_sub: RTL and testbench
===============================

Name: imf_sift_sub

Overview:
- Sifting-subtract stage of the EMD datapath. It sits directly downstream of the 30-cycle input delay line, whose output is the 16-bit signed delayed sample.
- It computes the local envelope mean, (upper + lower) / 2, subtracts it from the delayed sample and emits the IMF candidate h[n].
- It accumulates per-frame energy proxies and flags when the sifting stop criterion is met, so the controller can end the sift loop.

Parameters:
- W, 16: sample width; all data inputs and h_out are signed two's complement.
- FRAME_LEN, 256: samples per sift frame; range 2..65535.
- ACC_W, 32: width of the frame accumulators.
- STOP_SHIFT, 4: stop threshold. Stop when sum|mean| * 2^STOP_SHIFT < sum|x|.

Ports:
- CLK, in, 1: single clock; all logic on the rising edge.
- RST_N, in, 1: asynchronous active-low reset.
- x_in, in, W: delayed input sample, signed.
- env_up, in, W: upper envelope sample aligned with x_in, signed.
- env_lo, in, W: lower envelope sample aligned with x_in, signed.
- in_valid, in, 1: x_in, env_up and env_lo are valid this cycle.
- frame_start, in, 1: qualified by in_valid; marks sample index 0 of a frame.
- h_out, out, W: IMF candidate x - mean, saturated, signed.
- h_valid, out, 1: h_out is valid.
- sat_flag, out, 1: the current h_out was clipped; aligned with h_valid.
- frame_done, out, 1: one-cycle pulse with the h_valid of the last frame sample.
- sift_stop, out, 1: stop-criterion result of the most recent completed frame.

Behaviour:
- Reset (RST_N low, asynchronous):
  - h_out, h_valid, sat_flag, frame_done and sift_stop go to 0.
  - Pipeline valids, sample counter and both accumulators clear.
- Reset mid-frame discards the partial frame. After release, samples are discarded until in_valid and frame_start are both 1 (state IDLE).
- Pipeline, latency exactly 2 cycles from an accepted in_valid to h_valid. No backpressure; a gap in in_valid produces a gap in h_valid.
  - S1: sum = env_up + env_lo in W+1 bits; mean = sum >>> 1 (arithmetic, floor toward -inf). Register x, mean and valid.
  - S2: d = x - mean in W+1 bits. Saturate to [-2^(W-1), 2^(W-1)-1]; sat_flag = 1 when clipped. Register h_out, sat_flag and h_valid.
  - h_out holds its last value while h_valid = 0.
- Frame FSM, two states: IDLE and RUN.
  - IDLE: ignore samples (no h_valid) until in_valid and frame_start are both 1. That sample is index 0: go to RUN, and load the accumulators with that sample's |x| and |mean|.
  - RUN: each accepted sample increments cnt and adds to the accumulators.
  - A sample with frame_start during RUN restarts the frame at index 0. The partial frame is dropped and gives no frame_done.
  - At the sample with cnt = FRAME_LEN-1, evaluate the stop criterion and mark the frame done. The next accepted sample starts a new frame at index 0 (automatic wrap, stay in RUN); frame_start on it is allowed and harmless.
- Accumulation and stop criterion:
  - |v| is computed in W+1 bits, so |-32768| = 32768.
  - Each accumulator saturates at 2^ACC_W - 1 and never wraps.
  - Compare (sum_mean << STOP_SHIFT) < sum_x in ACC_W+STOP_SHIFT bits.
  - The result loads sift_stop in the same cycle frame_done pulses, i.e. aligned with the last h_valid of the frame. sift_stop holds until the next frame_done.
- frame_done is never asserted without h_valid.

Decomposition:
- Shared package emd_pkg:
  - W and the sample typedef (signed [W-1:0]).
  - SAMPLE_MAX and SAMPLE_MIN constants.
  - ACC_W default.
  - FSM state encoding (IDLE, RUN).
- One sub-module, sat_sub: (W+1)-bit subtract plus saturation, purely combinational, instanced in S2.
- The accumulators and FSM stay in imf_sift_sub.

Test Plan:
- Basic arithmetic, after reset, FRAME_LEN=4. Drive one valid sample x=1000, up=300, lo=-100 with frame_start=1 → mean=100; two cycles later h_out=900, h_valid=1, sat_flag=0.
- Floor rounding: up=3, lo=0, x=0 → mean=1, h_out=-1. Then up=-3, lo=0, x=0 → mean=-2, h_out=2.
- Saturation: x=32767, up=-32768, lo=-32768 → mean=-32768, h_out=32767, sat_flag=1. Then x=-32768, up=lo=32767 → h_out=-32768, sat_flag=1.
- Stop criterion, FRAME_LEN=4, STOP_SHIFT=4:
  - 4 samples x=1000, up=lo=10 → sum_x=4000, sum_mean=40, 640<4000 → frame_done pulse on 4th h_valid, sift_stop=1.
  - Next frame with up=lo=100 → 6400≥4000 → sift_stop=0.
- Gaps and restart:
  - in_valid toggling 1,0,1,0 → h_valid follows with 2-cycle latency; cnt advances only on valid cycles.
  - frame_start at index 2 → no frame_done for the partial frame; the next frame_done comes 4 valid samples after the restart.
- Reset mid-frame: assert RST_N low between samples → all outputs 0 immediately (asynchronous). After release, samples without frame_start give no h_valid until frame_start is seen.

Source files
------------

// File: rtl/emd_pkg.sv
// rtl/emd_pkg.sv - shared EMD datapath types, sample limits and frame FSM encoding.
package emd_pkg;

    localparam int W     = 16;
    localparam int ACC_W = 32;

    typedef logic signed [W-1:0] sample_t;

    localparam sample_t SAMPLE_MAX = sample_t'({1'b0, {(W-1){1'b1}}});
    localparam sample_t SAMPLE_MIN = sample_t'({1'b1, {(W-1){1'b0}}});

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sat_sub.sv
// rtl/sat_sub.sv - (W+1)-bit signed subtract a - b, clipped back to W bits.
module sat_sub #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                sat
);

    logic [W:0] d;

    always_comb begin
        d   = {a[W-1], a} - {b[W-1], b};
        // Overflow of the W-bit result shows as the top two bits disagreeing.
        sat = d[W] ^ d[W-1];
        y   = d[W-1:0];
        if (sat) begin
            y = d[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/imf_sift_sub.sv
// rtl/imf_sift_sub.sv - EMD sifting subtract: h = x - (up+lo)/2, with frame energy stop flag.
module imf_sift_sub #(
    parameter int W          = emd_pkg::W,
    parameter int FRAME_LEN  = 256,
    parameter int ACC_W      = emd_pkg::ACC_W,
    parameter int STOP_SHIFT = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] env_up,
    input  logic signed [W-1:0] env_lo,
    input  logic                in_valid,
    input  logic                frame_start,
    output logic signed [W-1:0] h_out,
    output logic                h_valid,
    output logic                sat_flag,
    output logic                frame_done,
    output logic                sift_stop
);

    import emd_pkg::*;

    localparam int CW = 16;
    localparam int CMP_W = ACC_W + STOP_SHIFT;

    function automatic logic [W:0] abs_w(input logic signed [W-1:0] v);
        logic signed [W:0] e;
        e = {v[W-1], v};
        return e[W] ? -e : e;
    endfunction

    state_t              state, state_n;
    logic [CW-1:0]       cnt, idx;
    logic [ACC_W-1:0]    acc_x, acc_m, acc_x_n, acc_m_n;
    logic [ACC_W:0]      sum_x, sum_m;
    logic                accept, last, stop_c;
    logic signed [W-1:0] mean_c;

    logic                s1_valid, s1_last, s1_stop;
    logic signed [W-1:0] s1_x, s1_mean;
    logic signed [W-1:0] d_c;
    logic                d_sat;

    always_comb begin
        state_n = state;
        accept  = in_valid && (state == RUN || frame_start);
        // frame_start (or leaving IDLE) forces index 0; otherwise cnt is the index.
        idx     = (state == IDLE || frame_start) ? '0 : cnt;
        last    = (idx == CW'(FRAME_LEN - 1));
        if (accept) begin
            state_n = RUN;
        end
    end

    always_comb begin
        mean_c  = W'(($signed({env_up[W-1], env_up}) + $signed({env_lo[W-1], env_lo})) >>> 1);
        sum_x   = {1'b0, (idx == '0) ? '0 : acc_x} + (ACC_W+1)'(abs_w(x_in));
        sum_m   = {1'b0, (idx == '0) ? '0 : acc_m} + (ACC_W+1)'(abs_w(mean_c));
        acc_x_n = sum_x[ACC_W] ? '1 : sum_x[ACC_W-1:0];
        acc_m_n = sum_m[ACC_W] ? '1 : sum_m[ACC_W-1:0];
        stop_c  = ((CMP_W'(acc_m_n) << STOP_SHIFT) < CMP_W'(acc_x_n));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt   <= '0;
            acc_x <= '0;
            acc_m <= '0;
        end else if (accept) begin
            cnt   <= last ? '0 : idx + 1'b1;
            acc_x <= acc_x_n;
            acc_m <= acc_m_n;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_stop  <= 1'b0;
            s1_x     <= '0;
            s1_mean  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= last;
                s1_stop <= stop_c;
                s1_x    <= x_in;
                s1_mean <= mean_c;
            end
        end
    end

    sat_sub #(.W(W)) u_sat_sub (
        .a   (s1_x),
        .b   (s1_mean),
        .y   (d_c),
        .sat (d_sat)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_out      <= '0;
            h_valid    <= 1'b0;
            sat_flag   <= 1'b0;
            frame_done <= 1'b0;
            sift_stop  <= 1'b0;
        end else begin
            h_valid    <= s1_valid;
            sat_flag   <= s1_valid && d_sat;
            frame_done <= s1_valid && s1_last;
            if (s1_valid) begin
                h_out <= d_c;
            end
            if (s1_valid && s1_last) begin
                sift_stop <= s1_stop;
            end
        end
    end

endmodule

// File: tb/tb_imf_sift_sub.sv
// tb/tb_imf_sift_sub.sv - scoreboard bench for imf_sift_sub against a frame-level reference model.
module tb_imf_sift_sub;

    import emd_pkg::*;

    localparam int FL = 4;
    localparam int SS = 4;
    localparam longint ACC_CAP = 64'h0000_0000_FFFF_FFFF;

    logic               CLK = 1'b0;
    logic               RST_N = 1'b0;
    logic signed [15:0] x_in = '0, env_up = '0, env_lo = '0;
    logic               in_valid = 1'b0, frame_start = 1'b0;
    logic signed [15:0] h_out;
    logic               h_valid, sat_flag, frame_done, sift_stop;

    imf_sift_sub #(.W(16), .FRAME_LEN(FL), .ACC_W(32), .STOP_SHIFT(SS)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .x_in        (x_in),
        .env_up      (env_up),
        .env_lo      (env_lo),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .h_out       (h_out),
        .h_valid     (h_valid),
        .sat_flag    (sat_flag),
        .frame_done  (frame_done),
        .sift_stop   (sift_stop)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int h;
        bit sat;
        bit fd;
        bit stop;
        int cyc;
    } exp_t;

    exp_t   sbq[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;

    bit     m_in_frame = 0;
    int     m_idx = 0;
    longint m_sx = 0, m_sm = 0;
    bit     m_stop = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0;
        m_idx = 0;
        m_sx = 0;
        m_sm = 0;
        m_stop = 0;
    endtask

    task automatic drive(input bit v, input bit fs, input int x, input int up, input int lo);
        exp_t e;
        int s, mean, d, idx;
        @(negedge CLK);
        in_valid    = v;
        frame_start = fs;
        x_in        = 16'(x);
        env_up      = 16'(up);
        env_lo      = 16'(lo);
        if (v && (m_in_frame || fs)) begin
            s    = up + lo;
            mean = (s >= 0) ? s / 2 : (s - 1) / 2;
            d    = x - mean;
            e.sat = 0;
            if (d > int'(SAMPLE_MAX)) begin d = SAMPLE_MAX; e.sat = 1; end
            if (d < int'(SAMPLE_MIN)) begin d = SAMPLE_MIN; e.sat = 1; end
            e.h = d;
            idx = (!m_in_frame || fs) ? 0 : m_idx;
            if (idx == 0) begin m_sx = 0; m_sm = 0; end
            m_sx += (x < 0) ? -x : x;
            m_sm += (mean < 0) ? -mean : mean;
            if (m_sx > ACC_CAP) m_sx = ACC_CAP;
            if (m_sm > ACC_CAP) m_sm = ACC_CAP;
            e.fd = (idx == FL - 1);
            if (e.fd) m_stop = ((m_sm << SS) < m_sx);
            m_idx = e.fd ? 0 : idx + 1;
            m_in_frame = 1;
            e.stop = m_stop;
            e.cyc = cyc + 2;
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    function automatic int rnd_s();
        case ($urandom_range(0, 7))
            0: return 32767;
            1: return -32768;
            2: return int'($urandom_range(0, 40)) - 20;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N) begin
            if (frame_done) chk("frame_done_needs_h_valid", h_valid, 1);
            if (h_valid) begin
                if (sbq.size() == 0) begin
                    chk("h_valid_unexpected", h_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("latency_cycle", cyc, e.cyc);
                    chk("h_out", h_out, e.h);
                    chk("sat_flag", sat_flag, e.sat);
                    chk("frame_done", frame_done, e.fd);
                    chk("sift_stop", sift_stop, e.stop);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_h_out", h_out, 0);
        chk("rst_h_valid", h_valid, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_sift_stop", sift_stop, 0);
        RST_N = 1'b1;
        idle(2);

        drive(1, 1, 1000, 300, -100);
        idle(3);
        drive(1, 0, 0, 3, 0);
        drive(1, 0, 0, -3, 0);
        drive(1, 0, 32767, -32768, -32768);
        drive(1, 0, -32768, 32767, 32767);
        idle(3);

        for (int i = 0; i < 4; i++) drive(1, i == 0, 1000, 10, 10);
        for (int i = 0; i < 4; i++) drive(1, 0, 1000, 100, 100);
        idle(3);

        for (int i = 0; i < 8; i++) drive(i % 2 == 0, i == 0, 500 + i, -200, 50);
        idle(2);

        drive(1, 1, 10, 0, 0);
        drive(1, 0, 20, 0, 0);
        drive(1, 1, 30, 2, 2);
        for (int i = 0; i < 4; i++) drive(1, 0, 40 + i, 2, 2);
        idle(3);

        for (int i = 0; i < 4; i++) drive(1, i == 0, -3000, 1, -1);
        drive(1, 0, 77, 5, 5);
        drive(1, 0, 88, 5, 5);
        idle(3);
        chk("pre_reset_sift_stop", sift_stop, m_stop);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst_h_out", h_out, 0);
        chk("async_rst_h_valid", h_valid, 0);
        chk("async_rst_sift_stop", sift_stop, 0);
        chk("async_rst_sat_flag", sat_flag, 0);
        model_reset();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) drive(1, 0, 123, 4, 4);
        for (int i = 0; i < 5; i++) drive(1, i == 0, 200 * i, -7, 3);
        idle(3);

        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rnd_s(), rnd_s(), rnd_s());
        end

        for (int i = 0; i < 10 && sbq.size() != 0; i++) idle(1);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
